// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC redirect sequencer: drives the PC mux selects, per-stage stall/flush controls,
// the trap-entry drain FSM and saturating redirect/stall performance counters.
module pc_redirect_ctrl #(
   parameter int unsigned DRAIN_MAX = 16,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             trap_req_i,
   input  logic             mem_busy_i,
   input  logic             if_stall_req_i,
   input  logic             load_use_i,
   input  logic             valid_exe_i,
   input  logic             br_taken_exe_i,
   input  logic             j_taken_exe_i,
   input  logic             pred_taken_exe_i,
   output logic             stall_o,
   output logic             switch_mode_o,
   output logic [1:0]       exe_change_o,
   output logic             stall_if_id_o,
   output logic             flush_if_id_o,
   output logic             flush_id_exe_o,
   output logic             flush_exe_mem_o,
   output logic             trap_ack_o,
   output logic             drain_timeout_o,
   output logic [CNT_W-1:0] redirect_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int unsigned DrainW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
   localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_MAX - 1);

   localparam logic [1:0] ExePc4  = 2'b00;
   localparam logic [1:0] ExeAlu  = 2'b10;
   localparam logic [1:0] ExeNone = 2'b11;

   typedef enum logic [1:0] {StNormal, StDrain, StRedirect} state_e;

   state_e            state_q, state_d;
   logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
   logic              drain_timeout_q, drain_timeout_d;
   logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic actual_taken;
   logic mispredict;

   assign actual_taken = br_taken_exe_i | j_taken_exe_i;
   assign mispredict   = valid_exe_i & (actual_taken != pred_taken_exe_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= StNormal;
         drain_cnt_q     <= '0;
         drain_timeout_q <= 1'b0;
         redirect_cnt_q  <= '0;
         stall_cnt_q     <= '0;
      end else begin
         state_q         <= state_d;
         drain_cnt_q     <= drain_cnt_d;
         drain_timeout_q <= drain_timeout_d;
         redirect_cnt_q  <= redirect_cnt_d;
         stall_cnt_q     <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      drain_cnt_d     = drain_cnt_q;
      drain_timeout_d = drain_timeout_q;
      unique case (state_q)
         StNormal: begin
            if (trap_req_i) begin
               state_d = mem_busy_i ? StDrain : StRedirect;
            end
         end
         StDrain: begin
            if (!mem_busy_i || (drain_cnt_q == DrainLast)) begin
               state_d     = StRedirect;
               drain_cnt_d = '0;
               // Leaving with memory still busy means the wait expired.
               if (mem_busy_i) begin
                  drain_timeout_d = 1'b1;
               end
            end else begin
               drain_cnt_d = drain_cnt_q + DrainW'(1);
            end
         end
         StRedirect: state_d = StNormal;
         default:    state_d = StNormal;
      endcase
   end

   always_comb begin
      stall_o         = 1'b0;
      switch_mode_o   = 1'b0;
      exe_change_o    = ExeNone;
      stall_if_id_o   = 1'b0;
      flush_if_id_o   = 1'b0;
      flush_id_exe_o  = 1'b0;
      flush_exe_mem_o = 1'b0;
      trap_ack_o      = 1'b0;
      if (!rst_i) begin
         unique case (state_q)
            StNormal: begin
               if (trap_req_i) begin
                  stall_o         = 1'b1;
                  flush_if_id_o   = 1'b1;
                  flush_id_exe_o  = 1'b1;
                  flush_exe_mem_o = 1'b1;
               end else if (mem_busy_i) begin
                  // Redirect waits: the branch stays in EXE while memory is busy.
                  stall_o       = 1'b1;
                  stall_if_id_o = 1'b1;
               end else if (mispredict) begin
                  exe_change_o   = actual_taken ? ExeAlu : ExePc4;
                  flush_if_id_o  = 1'b1;
                  flush_id_exe_o = 1'b1;
               end else if (load_use_i) begin
                  stall_o        = 1'b1;
                  stall_if_id_o  = 1'b1;
                  flush_id_exe_o = 1'b1;
               end else if (if_stall_req_i) begin
                  stall_o       = 1'b1;
                  flush_if_id_o = 1'b1;
               end
            end
            StDrain: begin
               stall_o         = 1'b1;
               flush_if_id_o   = 1'b1;
               flush_id_exe_o  = 1'b1;
               flush_exe_mem_o = 1'b1;
            end
            StRedirect: begin
               switch_mode_o   = 1'b1;
               trap_ack_o      = 1'b1;
               flush_if_id_o   = 1'b1;
               flush_id_exe_o  = 1'b1;
               flush_exe_mem_o = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      redirect_cnt_d = redirect_cnt_q;
      stall_cnt_d    = stall_cnt_q;
      if ((exe_change_o != ExeNone) && (redirect_cnt_q != '1)) begin
         redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
      end
      if ((state_q == StNormal) && stall_o && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   assign drain_timeout_o = drain_timeout_q;
   assign redirect_cnt_o  = redirect_cnt_q;
   assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Pipeline control sequencer for the fetch-PC mux. It produces the mux select signals: switch_mode, stall, exe_change.
- Produces per-stage stall and flush signals for IF/ID, ID/EXE and EXE/MEM.
- Sequences trap entry through a drain FSM and resolves EXE-stage branch mispredictions.
- Sits beside the PC mux in the 5-stage core. Keeps saturating counters of redirects and stalls.

Parameters:
- DRAIN_MAX, 16: maximum number of cycles to wait in DRAIN for mem_busy to fall.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- trap_req  in  1  exception/interrupt detected at MEM; held until trap_ack.
- mem_busy  in  1  data memory operation outstanding.
- if_stall_req  in  1  instruction memory not ready.
- load_use  in  1  load-use hazard detected in ID.
- valid_exe  in  1  EXE holds a valid instruction.
- br_taken_exe  in  1  resolved branch taken in EXE.
- j_taken_exe  in  1  jump in EXE.
- pred_taken_exe  in  1  IF had predicted this EXE instruction taken.
- stall  out  1  hold PC.
- switch_mode  out  1  select CSR trap/return target.
- exe_change  out  2  00 = pc_exe+4, 10 = alu_result_exe, 11 = no EXE redirect (01 never driven).
- stall_if_id  out  1  hold IF/ID register.
- flush_if_id  out  1  bubble IF/ID.
- flush_id_exe  out  1  bubble ID/EXE.
- flush_exe_mem  out  1  bubble EXE/MEM.
- trap_ack  out  1  one-cycle pulse when the trap is taken.
- drain_timeout  out  1  sticky flag: DRAIN expired.
- redirect_cnt  out  CNT_W  count of EXE redirects.
- stall_cnt  out  CNT_W  count of cycles with stall=1 in NORMAL.

Behaviour:
- **Output timing.** Control outputs are combinational from state and inputs. Counters, drain_timeout and the FSM are registered.
- **Reset (rst=1 at a clock edge):**
  - state goes to NORMAL; drain counter=0; drain_timeout=0; both counters=0.
  - All control outputs are 0, except exe_change, which is 11.
  - Reset mid-DRAIN aborts the trap with no trap_ack.
- **States:** NORMAL, DRAIN, REDIRECT.
- **NORMAL, evaluated in priority order:**
  1. trap_req=1:
     - Assert flush_if_id, flush_id_exe, flush_exe_mem and stall; exe_change=11.
     - Next state is DRAIN if mem_busy=1, else REDIRECT.
  2. mem_busy=1:
     - Assert stall and stall_if_id; no flushes; exe_change=11.
     - The EXE redirect is deferred, because the instruction remains in EXE.
  3. EXE redirect, when valid_exe=1 and actual≠pred_taken_exe, where actual = br_taken_exe|j_taken_exe:
     - actual=1 gives exe_change=10; actual=0 gives exe_change=00.
     - Assert flush_if_id and flush_id_exe; stall=0.
     - This case overrides load_use and if_stall_req.
  4. load_use=1:
     - Assert stall, stall_if_id and flush_id_exe.
  5. if_stall_req=1:
     - Assert stall and flush_if_id.
  6. Otherwise all outputs are idle, with exe_change=11.
- **DRAIN:**
  - Each cycle: stall=1, all three flushes asserted, exe_change=11; the drain counter increments.
  - Go to REDIRECT when mem_busy=0, or when the counter reaches DRAIN_MAX-1. In the timeout case, set drain_timeout=1.
  - The drain counter is cleared on exit.
- **REDIRECT (exactly one cycle):**
  - switch_mode=1, trap_ack=1, all three flushes asserted, stall=0, exe_change=11.
  - Next state is NORMAL.
  - trap_req must be low by the next cycle. If it is still high, a new trap sequence begins.
- **Counters:**
  - redirect_cnt increments on each cycle exe_change≠11.
  - stall_cnt increments on NORMAL cycles with stall=1.
  - Both saturate at all-ones; neither wraps.
- **drain_timeout** is cleared only by rst.

Test Plan:
1. Reset: hold rst for 2 cycles with random inputs → all control outputs are 0, exe_change=11, both counters=0, drain_timeout=0.
2. Mispredict: valid_exe=1, br_taken_exe=1, pred_taken_exe=0 → exe_change=10, flush_if_id=flush_id_exe=1, redirect_cnt=1.
   - Then j_taken_exe=0, br_taken_exe=0, pred_taken_exe=1 → exe_change=00, redirect_cnt=2.
3. Priority: mem_busy=1 together with the mispredict → exe_change=11, stall=1, stall_if_id=1; after mem_busy falls, exe_change=10.
   - load_use=1 together with the mispredict → exe_change=10, stall=0.
4. Trap drain: trap_req=1 with mem_busy=1 for 3 cycles → stall for 4 cycles (NORMAL + 3 DRAIN), then exactly one cycle of switch_mode=trap_ack=1, then NORMAL; drain_timeout=0.
5. Timeout: trap_req with mem_busy stuck at 1 → DRAIN lasts 16 cycles; switch_mode fires in cycle 17 after NORMAL; drain_timeout=1 until rst.
6. Saturation: CNT_W=4 with 20 consecutive load_use cycles → stall_cnt holds at 15.
